// File: rtl/gost_decrypt_pkg.sv
// Shared constants, state encoding, Magma Pi tables and key-schedule helpers for the GOST decryption core.
package gost_decrypt_pkg;

    localparam int unsigned ROUNDS    = 32;
    localparam int unsigned BLK_W     = 64;
    localparam int unsigned KEY_W     = 256;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned ROL_AMT   = 11;
    localparam int unsigned DEC_SPLIT = 8;
    localparam int unsigned ENC_SPLIT = 24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Magma Pi0..Pi7; row 0 substitutes the least significant nibble
    localparam logic [3:0] PI [8][16] = '{
        '{4'd12, 4'd4,  4'd6,  4'd2,  4'd10, 4'd5,  4'd11, 4'd9,  4'd14, 4'd8,  4'd13, 4'd7,  4'd0,  4'd3,  4'd15, 4'd1 },
        '{4'd6,  4'd8,  4'd2,  4'd3,  4'd9,  4'd10, 4'd5,  4'd12, 4'd1,  4'd14, 4'd4,  4'd7,  4'd11, 4'd13, 4'd0,  4'd15},
        '{4'd11, 4'd3,  4'd5,  4'd8,  4'd2,  4'd15, 4'd10, 4'd13, 4'd14, 4'd1,  4'd7,  4'd4,  4'd12, 4'd9,  4'd6,  4'd0 },
        '{4'd12, 4'd8,  4'd2,  4'd1,  4'd13, 4'd4,  4'd15, 4'd6,  4'd7,  4'd0,  4'd10, 4'd5,  4'd3,  4'd14, 4'd9,  4'd11},
        '{4'd7,  4'd15, 4'd5,  4'd10, 4'd8,  4'd1,  4'd6,  4'd13, 4'd0,  4'd9,  4'd3,  4'd14, 4'd11, 4'd4,  4'd2,  4'd12},
        '{4'd5,  4'd13, 4'd15, 4'd6,  4'd9,  4'd2,  4'd12, 4'd10, 4'd11, 4'd7,  4'd8,  4'd1,  4'd4,  4'd3,  4'd14, 4'd0 },
        '{4'd8,  4'd14, 4'd2,  4'd5,  4'd6,  4'd9,  4'd1,  4'd12, 4'd15, 4'd4,  4'd11, 4'd0,  4'd13, 4'd10, 4'd3,  4'd7 },
        '{4'd1,  4'd7,  4'd14, 4'd13, 4'd0,  4'd5,  4'd8,  4'd3,  4'd4,  4'd15, 4'd10, 4'd6,  4'd9,  4'd12, 4'd11, 4'd2 }
    };

    function automatic logic [3:0] s_box(input logic [2:0] row, input logic [3:0] x);
        return PI[row][x];
    endfunction

    // Zero-based subkey index for round r: ascending before the split, descending after it
    function automatic logic [2:0] key_sel(input logic [CNT_W-1:0] r, input logic enc);
        logic [CNT_W-1:0] split;
        split = enc ? CNT_W'(ENC_SPLIT) : CNT_W'(DEC_SPLIT);
        return (r < split) ? r[2:0] : (3'd7 - r[2:0]);
    endfunction

    // K1 lives in the top word of the key
    function automatic logic [WORD_W-1:0] key_word(input logic [KEY_W-1:0] key, input logic [2:0] sel);
        return WORD_W'(key >> {~sel, 5'd0});
    endfunction

endpackage

// File: rtl/gost_decrypt_round.sv
// Combinational Magma round function g(k,a) = ROL11(Pi(a + k)).
module gost_decrypt_round
    import gost_decrypt_pkg::*;
(
    input  logic [WORD_W-1:0] a_i,
    input  logic [WORD_W-1:0] k_i,
    output logic [WORD_W-1:0] g_c
);

    logic [WORD_W-1:0] sum;
    logic [WORD_W-1:0] sub;

    always_comb begin
        sum = a_i + k_i;
        sub = '0;
        for (int i = 0; i < 8; i++) begin
            sub[i*4 +: 4] = s_box(3'(i), sum[i*4 +: 4]);
        end
        g_c = (sub << ROL_AMT) | (sub >> (WORD_W - ROL_AMT));
    end

endmodule

// File: rtl/gost_decrypt.sv
// Iterative Magma decryption core, one Feistel round per clock, start/done handshake.
// Optional GOST_DEC_ENC_MODE_EN adds a mode input selecting the encryption key order.
module gost_decrypt
    import gost_decrypt_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [KEY_W-1:0]  key,
    input  logic [BLK_W-1:0]  iblock,
    output logic              busy,
    output logic              done,
    output logic [BLK_W-1:0]  oblock
`ifdef GOST_DEC_ENC_MODE_EN
    ,
    input  logic              mode
`endif
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    r_q, r_d;
    logic [KEY_W-1:0]    key_q, key_d;
    logic [WORD_W-1:0]   a1_q, a1_d;
    logic [WORD_W-1:0]   a0_q, a0_d;
    logic [BLK_W-1:0]    oblock_q, oblock_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                enc_q, enc_d;
    logic                enc_in;
    logic [WORD_W-1:0]   rkey;
    logic [WORD_W-1:0]   g;

`ifdef GOST_DEC_ENC_MODE_EN
    assign enc_in = mode;
`else
    assign enc_in = 1'b0;
`endif

    assign rkey = key_word(key_q, key_sel(r_q, enc_q));

    gost_decrypt_round u_round (
        .a_i (a0_q),
        .k_i (rkey),
        .g_c (g)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            r_q      <= '0;
            key_q    <= '0;
            a1_q     <= '0;
            a0_q     <= '0;
            oblock_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            enc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            key_q    <= key_d;
            a1_q     <= a1_d;
            a0_q     <= a0_d;
            oblock_q <= oblock_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            enc_q    <= enc_d;
        end
    end

    // DONE accepts start like IDLE so back-to-back blocks lose no cycle
    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        key_d    = key_q;
        a1_d     = a1_q;
        a0_d     = a0_q;
        oblock_d = oblock_q;
        enc_d    = enc_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    state_d = ST_RUN;
                    key_d   = key;
                    a1_d    = iblock[BLK_W-1:WORD_W];
                    a0_d    = iblock[WORD_W-1:0];
                    enc_d   = enc_in;
                    r_d     = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                if (r_q == CNT_W'(ROUNDS - 1)) begin
                    oblock_d = {g ^ a1_q, a0_q};
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                end else begin
                    a1_d   = a0_q;
                    a0_d   = g ^ a1_q;
                    r_d    = r_q + CNT_W'(1);
                    busy_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign oblock = oblock_q;

endmodule
